// File: rtl/noise_pattern_gen.sv
// PRBS7 serial test-stream transmitter with preamble and periodic error injection.
// Optional NOISE_GEN_MANUAL_INJ_EN adds an inject_now input for on-demand bit flips.
module noise_pattern_gen #(
    parameter int unsigned PRE_LEN    = 8,
    parameter int unsigned ERR_PERIOD = 16,
    parameter logic [6:0]  SEED       = 7'h7F,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             inject_en,
`ifdef NOISE_GEN_MANUAL_INJ_EN
    input  logic             inject_now,
`endif
    output logic             out_bit,
    output logic             bit_valid,
    output logic             in_run,
    output logic             err_strobe,
    output logic [CNT_W-1:0] inj_count
);

    typedef enum logic [1:0] {IDLE, PRE, RUN} state_e;

    // An all-zero seed would lock the LFSR, so it falls back to all-ones.
    localparam logic [6:0]  SEED_L   = (SEED == 7'h00) ? 7'h7F : SEED;
    localparam logic [15:0] BIT_LAST = 16'(ERR_PERIOD - 1);
    localparam logic [7:0]  PRE_LAST = 8'(PRE_LEN);

    state_e             state_q, state_d;
    logic [6:0]         lfsr_q, lfsr_d;
    logic [15:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]         pre_cnt_q, pre_cnt_d;
    logic               out_q, out_d;
    logic               vld_q, vld_d;
    logic               run_q, run_d;
    logic               str_q, str_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               raw;
    logic               flip;
    logic [6:0]         lfsr_nxt;

    assign raw      = lfsr_q[6];
    assign lfsr_nxt = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED_L;
            bit_cnt_q <= '0;
            pre_cnt_q <= '0;
            out_q     <= 1'b0;
            vld_q     <= 1'b0;
            run_q     <= 1'b0;
            str_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            bit_cnt_q <= bit_cnt_d;
            pre_cnt_q <= pre_cnt_d;
            out_q     <= out_d;
            vld_q     <= vld_d;
            run_q     <= run_d;
            str_q     <= str_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        bit_cnt_d = bit_cnt_q;
        pre_cnt_d = pre_cnt_q;
        cnt_d     = cnt_q;
        out_d     = 1'b0;
        vld_d     = 1'b0;
        run_d     = 1'b0;
        str_d     = 1'b0;
        flip      = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = PRE;
                    out_d     = 1'b1;
                    vld_d     = 1'b1;
                    pre_cnt_d = 8'd1;
                    lfsr_d    = SEED_L;
                end
                PRE: begin
                    vld_d = 1'b1;
                    if (pre_cnt_q == PRE_LAST) begin
                        // The transition edge already presents RUN bit 0, so the
                        // cleared counter resumes at 1.
                        state_d   = RUN;
                        run_d     = 1'b1;
                        out_d     = raw;
                        lfsr_d    = lfsr_nxt;
                        bit_cnt_d = 16'd1;
                    end else begin
                        out_d     = ~pre_cnt_q[0];
                        pre_cnt_d = pre_cnt_q + 8'd1;
                    end
                end
                RUN: begin
                    vld_d = 1'b1;
                    run_d = 1'b1;
                    flip  = inject_en && (bit_cnt_q == BIT_LAST);
`ifdef NOISE_GEN_MANUAL_INJ_EN
                    flip  = flip || inject_now;
`endif
                    out_d     = raw ^ flip;
                    str_d     = flip;
                    if (flip) cnt_d = cnt_q + 1'b1;
                    lfsr_d    = lfsr_nxt;
                    bit_cnt_d = (bit_cnt_q == BIT_LAST) ? 16'd0 : bit_cnt_q + 16'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign out_bit    = out_q;
    assign bit_valid  = vld_q;
    assign in_run     = run_q;
    assign err_strobe = str_q;
    assign inj_count  = cnt_q;

endmodule

// File: tb/tb_noise_pattern_gen.sv
// Bench for noise_pattern_gen: session-indexed stream model plus a receive-side error counter.
module tb_noise_pattern_gen;
    localparam int PRE_LEN    = 8;
    localparam int ERR_PERIOD = 16;
    localparam int CNT_W      = 4;

    logic clk = 1'b0;
    logic reset, enable, inject_en, inject_now;
    logic out_bit, bit_valid, in_run, err_strobe;
    logic [CNT_W-1:0] inj_count;

    int errors = 0;
    int checks = 0;

    bit prbs [127];
    int idx     = -1;   // position in current enabled session, -1 when idle
    int exp_cnt = 0;
    int rx_cnt  = 0;
    int strobes = 0;
    logic [7:0] first8;

    always #10 clk = ~clk;

    noise_pattern_gen #(
        .PRE_LEN(PRE_LEN), .ERR_PERIOD(ERR_PERIOD), .SEED(7'h7F), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .inject_en(inject_en),
`ifdef NOISE_GEN_MANUAL_INJ_EN
        .inject_now(inject_now),
`endif
        .out_bit(out_bit), .bit_valid(bit_valid), .in_run(in_run),
        .err_strobe(err_strobe), .inj_count(inj_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out"}, 16'(out_bit), 16'd0);
        chk({tag, "_vld"}, 16'(bit_valid), 16'd0);
        chk({tag, "_run"}, 16'(in_run), 16'd0);
        chk({tag, "_str"}, 16'(err_strobe), 16'd0);
    endtask

    // One clock with the given inputs; the model predicts the registered outputs.
    task automatic step(input logic en, input logic inj, input logic now);
        logic e_out, e_vld, e_run, e_str, raw, flip;
        int r;
        enable = en; inject_en = inj; inject_now = now;
        @(posedge clk);
        idx = en ? idx + 1 : -1;
        e_out = 1'b0; e_vld = (idx >= 0); e_run = (idx >= PRE_LEN); e_str = 1'b0;
        raw = 1'b0; r = idx - PRE_LEN;
        if (idx >= 0 && idx < PRE_LEN) e_out = ((idx % 2) == 0);
        if (e_run) begin
            raw  = prbs[r % 127];
            flip = inj && (((r + 1) % ERR_PERIOD) == 0);
`ifdef NOISE_GEN_MANUAL_INJ_EN
            flip = flip || (now && r > 0);
`endif
            e_out = raw ^ flip;
            e_str = flip;
            if (flip) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        end
        #1;
        chk("out_bit", 16'(out_bit), 16'(e_out));
        chk("bit_valid", 16'(bit_valid), 16'(e_vld));
        chk("in_run", 16'(in_run), 16'(e_run));
        chk("err_strobe", 16'(err_strobe), 16'(e_str));
        chk("inj_count", 16'(inj_count), 16'(exp_cnt));
        if (in_run === 1'b1 && e_run && out_bit !== raw) rx_cnt = (rx_cnt + 1) % (1 << CNT_W);
        if (err_strobe === 1'b1) begin
            strobes++;
            chk("rx_vs_inj", 16'(rx_cnt), 16'(inj_count));
        end
    endtask

    initial begin
        logic [6:0] seed;
        seed = 7'h7F;
        for (int i = 0; i < 7; i++) prbs[i] = seed[6 - i];
        for (int i = 7; i < 127; i++) prbs[i] = prbs[i - 7] ^ prbs[i - 6];

        // Reset state
        reset = 1'b0; enable = 1'b0; inject_en = 1'b0; inject_now = 1'b0;
        #40;
        chk_idle("reset");
        chk("reset_cnt", 16'(inj_count), 16'd0);
        @(negedge clk) reset = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // Clean stream: preamble then PRBS, first RUN byte 1111_1110
        first8 = '0;
        repeat (PRE_LEN) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0);
            first8 = {first8[6:0], out_bit};
        end
        chk("first8_run", 16'(first8), 16'h00FE);
        repeat (140) step(1'b1, 1'b0, 1'b0);
        chk("no_strobe_clean", 16'(strobes), 16'd0);

        // Periodic injection over 160 RUN bits -> 10 strobes
        step(1'b0, 1'b0, 1'b0);
        repeat (PRE_LEN + 160) step(1'b1, 1'b1, 1'b0);
        chk("strobes_160", 16'(strobes), 16'd10);
        chk("inj_cnt_10", 16'(inj_count), 16'd10);

        // Continue to 17 injections -> wrap to 1
        repeat (112) step(1'b1, 1'b1, 1'b0);
        chk("inj_cnt_wrap", 16'(inj_count), 16'd1);

        // Abort mid-preamble, then full restart
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk_idle("abort");
        repeat (PRE_LEN + 40) step(1'b1, 1'b1, 1'b0);

        // Asynchronous reset mid-stream
        #3 reset = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_cnt", 16'(inj_count), 16'd0);
        idx = -1; exp_cnt = 0; rx_cnt = 0;
        @(negedge clk) reset = 1'b1;

`ifdef NOISE_GEN_MANUAL_INJ_EN
        // Manual pulses on RUN bits 5 and 16
        repeat (PRE_LEN) step(1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 16; n++) step(1'b1, 1'b0, (n == 5 || n == 16));
        chk("manual_cnt", 16'(inj_count), 16'd2);
        // Coincident manual and periodic on bit 32: single increment
        for (int n = 17; n <= 32; n++) step(1'b1, 1'b1, (n == 32));
        chk("coincident_cnt", 16'(inj_count), 16'd3);
        step(1'b0, 1'b0, 1'b0);
`endif

        // Randomized enable / inject pattern
        for (int i = 0; i < 800; i++)
            step(($urandom % 60) != 0, ($urandom % 4) != 0, ($urandom % 19) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
